// File: rtl/sw_rsp_nto_m_pkg.sv
// Shared widths, helpers and slice payload type for the response-return crossbar.
package sw_pkg;

    localparam int unsigned DEF_IN_N  = 5;
    localparam int unsigned DEF_OUT_N = 5;
    localparam int unsigned RSP_TAG_W = 32;
    localparam int unsigned DEF_DEPTH = 4;

    // Index width that never collapses to zero for single-entry sets.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_IN_W  = idx_w(DEF_IN_N);
    localparam int unsigned DEF_OUT_W = idx_w(DEF_OUT_N);

    typedef struct packed {
        logic                 vld;
        logic [RSP_TAG_W-1:0] tag;
    } rsp_slice_t;

endpackage

// File: rtl/sw_rsp_nto_m_rr_arb.sv
// N-way round-robin arbiter; search starts at the pointer, which moves past the winner on a grant.
module sw_rr_arb
    import sw_pkg::*;
#(
    parameter int unsigned N = DEF_OUT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt_c
);

    localparam int unsigned W = idx_w(N);

    logic [W-1:0] ptr;
    logic [W-1:0] win;
    logic [W-1:0] nxt;
    logic         found;

    always_comb begin
        gnt_c = '0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[W'(idx)]) begin
                found = 1'b1;
                win   = W'(idx);
            end
        end
        if (en && found) gnt_c[win] = 1'b1;
        nxt = (win == W'(N - 1)) ? '0 : win + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= nxt;
        end
    end

endmodule

// File: rtl/sw_rsp_nto_m.sv
// Response-return crossbar: tracks request sources per downstream port and routes
// in-order responses back through per-upstream round-robin arbiters and register slices.
module sw_rsp_nto_m
    import sw_pkg::*;
#(
    parameter int unsigned IN_N  = DEF_IN_N,
    parameter int unsigned OUT_N = DEF_OUT_N,
    parameter int unsigned TAG_W = RSP_TAG_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OUT_N-1:0]         reqfire_i,
    input  logic [OUT_N*idx_w(IN_N)-1:0] reqsrc_i,
    output logic [OUT_N-1:0]         reqfull_o,
    input  logic [OUT_N-1:0]         dnrsp_i,
    input  logic [OUT_N*TAG_W-1:0]   dnrsptag_i,
    output logic [OUT_N-1:0]         dnrsprdy_o,
    output logic [IN_N-1:0]          uprsp_o,
    output logic [IN_N*TAG_W-1:0]    uprsptag_o,
    input  logic [IN_N-1:0]          uprsprdy_i,
    output logic [OUT_N-1:0]         err_o
);

    localparam int unsigned IN_W  = idx_w(IN_N);
    localparam int unsigned PTR_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [IN_W-1:0]  fifo_mem [OUT_N][DEPTH];
    logic [PTR_W-1:0] wptr [OUT_N];
    logic [PTR_W-1:0] rptr [OUT_N];
    logic [CNT_W-1:0] cnt  [OUT_N];
    logic [IN_W-1:0]  head [OUT_N];

    logic [OUT_N-1:0] empty;
    logic [OUT_N-1:0] full;
    logic [OUT_N-1:0] push_ok;
    logic [OUT_N-1:0] pop;
    logic [OUT_N-1:0] err_set;

    logic [OUT_N-1:0] arb_req [IN_N];
    logic [OUT_N-1:0] arb_gnt [IN_N];
    logic [IN_N-1:0]  load_en;
    logic [IN_N-1:0]  grant_any;
    logic [TAG_W-1:0] sel_tag [IN_N];

    // FIFO status and front entries
    always_comb begin
        empty = '0;
        full  = '0;
        for (int j = 0; j < OUT_N; j++) begin
            empty[j] = (cnt[j] == CNT_W'(0));
            full[j]  = (cnt[j] == CNT_W'(DEPTH));
            head[j]  = fifo_mem[j][rptr[j]];
        end
    end

    assign reqfull_o = full;

    // Port j competes only in the arbiter of the upstream that issued its oldest request.
    always_comb begin
        for (int i = 0; i < IN_N; i++) begin
            arb_req[i] = '0;
            for (int j = 0; j < OUT_N; j++) begin
                arb_req[i][j] = dnrsp_i[j] && !empty[j] && (head[j] == IN_W'(i));
            end
        end
    end

    assign load_en = ~uprsp_o | uprsprdy_i;

    for (genvar gi = 0; gi < IN_N; gi++) begin : g_arb
        sw_rr_arb #(
            .N (OUT_N)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (arb_req[gi]),
            .en    (load_en[gi]),
            .gnt_c (arb_gnt[gi])
        );
    end

    // Grants fan back to downstream ready and select the tag for each slice.
    always_comb begin
        dnrsprdy_o = '0;
        grant_any  = '0;
        for (int i = 0; i < IN_N; i++) begin
            dnrsprdy_o   = dnrsprdy_o | arb_gnt[i];
            grant_any[i] = |arb_gnt[i];
            sel_tag[i]   = '0;
            for (int j = 0; j < OUT_N; j++) begin
                if (arb_gnt[i][j]) sel_tag[i] = sel_tag[i] | dnrsptag_i[j*TAG_W +: TAG_W];
            end
        end
    end

    assign pop     = dnrsprdy_o;
    assign push_ok = reqfire_i & (~full | pop);
    assign err_set = (reqfire_i & full & ~pop) | (dnrsp_i & empty);

    // Storage has no reset; entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        for (int j = 0; j < OUT_N; j++) begin
            if (push_ok[j]) fifo_mem[j][wptr[j]] <= reqsrc_i[j*IN_W +: IN_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_N; j++) begin
                wptr[j] <= '0;
                rptr[j] <= '0;
                cnt[j]  <= '0;
            end
            err_o <= '0;
        end else begin
            for (int j = 0; j < OUT_N; j++) begin
                if (push_ok[j]) wptr[j] <= wptr[j] + PTR_W'(1);
                if (pop[j])     rptr[j] <= rptr[j] + PTR_W'(1);
                if (push_ok[j] && !pop[j]) begin
                    cnt[j] <= cnt[j] + CNT_W'(1);
                end else if (!push_ok[j] && pop[j]) begin
                    cnt[j] <= cnt[j] - CNT_W'(1);
                end
            end
            err_o <= err_o | err_set;
        end
    end

    // Upstream register slices
    always_ff @(posedge clk) begin
        if (rst) begin
            uprsp_o    <= '0;
            uprsptag_o <= '0;
        end else begin
            for (int i = 0; i < IN_N; i++) begin
                if (grant_any[i]) begin
                    uprsp_o[i]                   <= 1'b1;
                    uprsptag_o[i*TAG_W +: TAG_W] <= sel_tag[i];
                end else if (uprsprdy_i[i]) begin
                    uprsp_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule
